// File: rtl/lut_sched_pkg.sv
// Shared types and helpers for the time-multiplexed LUT layer scheduler.
// Also provides the parity function used when LUT_PARITY_EN is defined.
package lut_sched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StHold
    } state_e;

    function automatic int unsigned calc_aw(input int unsigned fanin, input int unsigned bw);
        return fanin * bw;
    endfunction

    function automatic int unsigned calc_selw(input int unsigned in_acts);
        return (in_acts > 1) ? $clog2(in_acts) : 1;
    endfunction

    function automatic int unsigned calc_nw(input int unsigned neurons);
        return (neurons > 1) ? $clog2(neurons) : 1;
    endfunction

    // Even parity: the returned bit makes the total number of ones even.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/lut_neuron_ram.sv
// Truth-table store for all neurons: one write port, one registered read port.
// A same-cycle write to the read address is forwarded so the read sees new data.
module lut_neuron_ram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned DW    = 2,
    parameter int unsigned ABITS = 10
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [ABITS-1:0] waddr_i,
    input  logic [DW-1:0]    wdata_i,
    input  logic [ABITS-1:0] raddr_i,
    output logic [DW-1:0]    rdata_o
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (we_i && (waddr_i == raddr_i)) begin
            rdata_q <= wdata_i;
        end else begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lut_layer_scheduler.sv
// Evaluates NEURONS LUT neurons sequentially through one shared truth-table RAM.
// Define LUT_PARITY_EN to store a parity bit per entry and flag read mismatches.
module lut_layer_scheduler
    import lut_sched_pkg::*;
#(
    parameter int unsigned IN_ACTS = 32,
    parameter int unsigned NEURONS = 16,
    parameter int unsigned FANIN   = 3,
    parameter int unsigned BW      = 2,
    localparam int unsigned AW     = calc_aw(FANIN, BW),
    localparam int unsigned SELW   = calc_selw(IN_ACTS),
    localparam int unsigned NW     = calc_nw(NEURONS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_ACTS*BW-1:0]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NEURONS*BW-1:0]   out_data,
    input  logic                    cfg_we,
    input  logic [NW+AW-1:0]        cfg_addr,
    input  logic [BW-1:0]           cfg_wdata,
    input  logic                    sel_we,
    input  logic [NW-1:0]           sel_neuron,
    input  logic [FANIN*SELW-1:0]   sel_data,
    output logic                    cfg_ready,
    output logic                    busy,
    output logic                    parity_err
);

`ifdef LUT_PARITY_EN
    localparam int unsigned RDW = BW + 1;
`else
    localparam int unsigned RDW = BW;
`endif
    localparam int unsigned NSEL  = 2 ** SELW;
    localparam int unsigned DEPTH = NEURONS * (2 ** AW);

    state_e                  state_q, state_d;
    logic [NW-1:0]           n_q;
    logic [IN_ACTS*BW-1:0]   in_q;
    logic [FANIN*SELW-1:0]   sel_q [NEURONS];
    logic [NEURONS*BW-1:0]   out_q;
    logic                    rd_valid_q;
    logic [NW-1:0]           rd_n_q;

    logic                    cfg_ok;
    logic                    sel_ok;
    logic                    last_issue;
    logic [BW-1:0]           acts [NSEL];
    logic [AW-1:0]           lut_a;
    logic [RDW-1:0]          ram_wdata;
    logic [RDW-1:0]          ram_rdata;

    assign cfg_ok     = cfg_we & cfg_ready;
    assign sel_ok     = sel_we & cfg_ready;
    assign last_issue = (n_q == NW'(NEURONS - 1));

    // Indices beyond the input vector alias to activation 0.
    for (genvar k = 0; k < NSEL; k++) begin : g_act
        if (k < IN_ACTS) begin : g_real
            assign acts[k] = in_q[k*BW +: BW];
        end else begin : g_alias
            assign acts[k] = in_q[BW-1:0];
        end
    end

    // Fan-in 0 lands in the address LSBs.
    always_comb begin
        lut_a = '0;
        for (int f = 0; f < FANIN; f++) begin
            lut_a[f*BW +: BW] = acts[sel_q[n_q][f*SELW +: SELW]];
        end
    end

`ifdef LUT_PARITY_EN
    assign ram_wdata = {even_parity(8'(cfg_wdata)), cfg_wdata};
`else
    assign ram_wdata = cfg_wdata;
`endif

    lut_neuron_ram #(
        .DEPTH (DEPTH),
        .DW    (RDW),
        .ABITS (NW + AW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (cfg_ok),
        .waddr_i (cfg_addr),
        .wdata_i (ram_wdata),
        .raddr_i ({n_q, lut_a}),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StIssue;
            StIssue: if (last_issue) state_d = StDrain;
            StDrain: state_d = StHold;
            StHold:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        cfg_ready = (state_q == StIdle);
        busy      = (state_q != StIdle);
        out_valid = (state_q == StHold);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q        <= '0;
            in_q       <= '0;
            out_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_n_q     <= '0;
            for (int i = 0; i < NEURONS; i++) begin
                sel_q[i] <= '0;
            end
        end else begin
            if (state_q == StIdle && in_valid) begin
                in_q <= in_data;
                n_q  <= '0;
            end else if (state_q == StIssue) begin
                n_q <= n_q + 1'b1;
            end
            if (sel_ok) begin
                sel_q[sel_neuron] <= sel_data;
            end
            // Read data returns one cycle after issue; tag it with its neuron.
            rd_valid_q <= (state_q == StIssue);
            rd_n_q     <= n_q;
            if (rd_valid_q) begin
                out_q[rd_n_q*BW +: BW] <= ram_rdata[BW-1:0];
            end
        end
    end

`ifdef LUT_PARITY_EN
    logic parity_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
        end else if (rd_valid_q && (^ram_rdata)) begin
            parity_err_q <= 1'b1;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign out_data = out_q;

endmodule
